// File: rtl/microwave_pkg.sv
// Shared microwave front-end types: keypad geometry, encoder states, key helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package microwave_pkg;

  localparam int KEY_WIDTH   = 10;
  localparam int DIGIT_WIDTH = 4;

  typedef enum logic [1:0] {
    KE_IDLE     = 2'd0,
    KE_DEBOUNCE = 2'd1,
    KE_HELD     = 2'd2,
    KE_LOCKOUT  = 2'd3
  } ke_state_t;

  typedef enum logic [1:0] {
    KC_NONE  = 2'd0,
    KC_ONE   = 2'd1,
    KC_MULTI = 2'd2
  } key_class_t;

  // Sort a keypad sample into no key, a single key, or several keys at once.
  function automatic key_class_t classify_keys(input logic [KEY_WIDTH-1:0] keys);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (keys[i]) n++;
    end
    if (n == 0)      return KC_NONE;
    else if (n == 1) return KC_ONE;
    else             return KC_MULTI;
  endfunction

  // One-hot key lines to BCD; bit n maps to digit n. Only meaningful for one-hot input.
  function automatic logic [DIGIT_WIDTH-1:0] onehot_to_bcd(input logic [KEY_WIDTH-1:0] keys);
    logic [DIGIT_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (keys[i]) d = DIGIT_WIDTH'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/keypad_encoder_stable_counter.sv
// Counts consecutive stable samples; pulses hit when the run reaches MAX_COUNT.
// Latency: hit is combinational from this cycle's command; count updates at the edge.
// Backpressure: none; a hit consumes the run so the next phase starts from zero.
module stable_counter #(
  parameter int unsigned MAX_COUNT = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  input  logic advance,
  output logic hit
);

  localparam logic [CNT_W:0] MAX_W = (CNT_W + 1)'(MAX_COUNT);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;
  logic [CNT_W:0]   next_val;

  assign count_inc = {1'b0, count} + (CNT_W + 1)'(1);

  // Next run length: a new run starts at one, a continued run saturates at the limit.
  always_comb begin
    next_val = '0;
    if (restart) begin
      next_val = (CNT_W + 1)'(1);
    end else if (advance) begin
      next_val = (count_inc > MAX_W) ? MAX_W : count_inc;
    end
  end

  assign hit = (restart || advance) && (next_val >= MAX_W);

  // Hold the run length; any other command (or a hit) drops it back to zero.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (hit) begin
      count <= '0;
    end else begin
      count <= next_val[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Debounces the one-hot keypad, rejects multi-key presses, emits one BCD digit strobe per press.
// Latency: DEBOUNCE_CYCLES+1 edges from a clean press to valid (one input register + debounce).
// Backpressure: none; a press accepted while enable=0 is consumed without a strobe.
module keypad_encoder
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [KEY_WIDTH-1:0]   keypad,
  output logic [DIGIT_WIDTH-1:0] digit,
  output logic                   valid,
  output logic                   pressed,
  output logic                   multi_err
);

  ke_state_t            state;
  logic [KEY_WIDTH-1:0] kp_q;
  logic [KEY_WIDTH-1:0] cand;
  key_class_t           kp_class;
  logic                 cnt_restart;
  logic                 cnt_advance;
  logic                 cnt_hit;

  assign kp_class = classify_keys(kp_q);

  // One counter serves press debounce and both release paths.
  stable_counter #(
    .MAX_COUNT (DEBOUNCE_CYCLES)
  ) u_stable (
    .clock   (clock),
    .clear   (clear),
    .restart (cnt_restart),
    .advance (cnt_advance),
    .hit     (cnt_hit)
  );

  // Tell the counter whether this sample starts, extends or breaks a stable run.
  always_comb begin
    cnt_restart = 1'b0;
    cnt_advance = 1'b0;
    case (state)
      KE_IDLE: begin
        cnt_restart = (kp_class == KC_ONE);
      end
      KE_DEBOUNCE: begin
        if (kp_class == KC_ONE) begin
          if (kp_q == cand) cnt_advance = 1'b1;
          else              cnt_restart = 1'b1;
        end
      end
      KE_HELD, KE_LOCKOUT: begin
        cnt_advance = (kp_class == KC_NONE);
      end
      default: ;
    endcase
  end

  // Input register, press/release state machine and registered outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      kp_q      <= '0;
      cand      <= '0;
      state     <= KE_IDLE;
      digit     <= '0;
      valid     <= 1'b0;
      pressed   <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      kp_q      <= keypad;
      valid     <= 1'b0;
      multi_err <= 1'b0;
      case (state)
        KE_IDLE: begin
          if (kp_class == KC_MULTI) begin
            state     <= KE_LOCKOUT;
            multi_err <= 1'b1;
          end else if (kp_class == KC_ONE) begin
            cand <= kp_q;
            if (cnt_hit) begin
              state   <= KE_HELD;
              digit   <= onehot_to_bcd(kp_q);
              pressed <= 1'b1;
              valid   <= enable;
            end else begin
              state <= KE_DEBOUNCE;
            end
          end
        end
        KE_DEBOUNCE: begin
          if (kp_class == KC_NONE) begin
            state <= KE_IDLE;
          end else if (kp_class == KC_MULTI) begin
            state     <= KE_LOCKOUT;
            multi_err <= 1'b1;
          end else begin
            // A different single key restarts the run around the new candidate.
            cand <= kp_q;
            if (cnt_hit) begin
              state   <= KE_HELD;
              digit   <= onehot_to_bcd(kp_q);
              pressed <= 1'b1;
              valid   <= enable;
            end
          end
        end
        KE_HELD: begin
          if (cnt_hit) begin
            state   <= KE_IDLE;
            pressed <= 1'b0;
          end
        end
        KE_LOCKOUT: begin
          multi_err <= (kp_class == KC_MULTI);
          if (cnt_hit) begin
            state <= KE_IDLE;
          end
        end
        default: state <= KE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a sliding-window reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_encoder;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       clear;
  logic       enable;
  logic [9:0] keypad;
  logic [3:0] digit;
  logic       valid;
  logic       pressed;
  logic       multi_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clock     (clock),
    .clear     (clear),
    .enable    (enable),
    .keypad    (keypad),
    .digit     (digit),
    .valid     (valid),
    .pressed   (pressed),
    .multi_err (multi_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a key is accepted once the last D input samples are the same single
  // key; a hold or lockout ends once the last D samples are all zero.
  typedef enum {P_FREE, P_HELD, P_LOCK} phase_t;
  phase_t     phase = P_FREE;
  bit         model_live = 1'b0;
  logic [9:0] m_kp;
  logic [9:0] hist[$];
  logic [3:0] m_digit;
  logic       m_valid, m_pressed, m_multi;

  function automatic bit window_is(input logic [9:0] v);
    if (hist.size() != D) return 1'b0;
    foreach (hist[i]) if (hist[i] !== v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (clear) begin
      model_live = 1'b1;
      phase      = P_FREE;
      m_kp       = '0;
      hist.delete();
      m_digit    = '0;
      m_valid    = 1'b0;
      m_pressed  = 1'b0;
      m_multi    = 1'b0;
    end else if (model_live) begin
      hist.push_front(m_kp);
      if (hist.size() > D) void'(hist.pop_back());
      m_valid = 1'b0;
      case (phase)
        P_FREE: begin
          if ($countones(m_kp) >= 2) begin
            phase   = P_LOCK;
            m_multi = 1'b1;
          end else if ($countones(m_kp) == 1 && window_is(m_kp)) begin
            for (int i = 0; i < 10; i++) if (m_kp[i]) m_digit = 4'(i);
            phase     = P_HELD;
            m_pressed = 1'b1;
            m_valid   = enable;
          end
        end
        P_HELD: begin
          if (window_is('0)) begin
            phase     = P_FREE;
            m_pressed = 1'b0;
          end
        end
        default: begin
          m_multi = ($countones(m_kp) >= 2);
          if (window_is('0)) phase = P_FREE;
        end
      endcase
      m_kp = keypad;
    end
  end

  // Compare every cycle and record strobes / level statistics for the directed checks.
  int  strobe_q[$];
  int  strobe_cyc[$];
  int  fall_cyc = -1;
  int  multi_hi = 0;
  int  pressed_hi = 0;
  logic prev_pressed = 1'b0;

  always @(negedge clock) begin
    if (model_live) begin
      chk("digit",     32'(digit),     32'(m_digit));
      chk("valid",     32'(valid),     32'(m_valid));
      chk("pressed",   32'(pressed),   32'(m_pressed));
      chk("multi_err", 32'(multi_err), 32'(m_multi));
      if (valid === 1'b1) begin
        strobe_q.push_back(int'(digit));
        strobe_cyc.push_back(cyc);
      end
      if (prev_pressed === 1'b1 && pressed === 1'b0) fall_cyc = cyc;
      if (multi_err === 1'b1) multi_hi++;
      if (pressed === 1'b1) pressed_hi++;
      prev_pressed = pressed;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic reset_log();
    strobe_q.delete();
    strobe_cyc.delete();
    multi_hi   = 0;
    pressed_hi = 0;
    fall_cyc   = -1;
  endtask

  task automatic pad_log(input int n);
    while (strobe_q.size() < n) begin
      strobe_q.push_back(-1);
      strobe_cyc.push_back(-1);
    end
  endtask

  int t_apply, t_rel, n_str;
  int seq_keys[3] = '{5, 0, 3};

  initial begin
    clear  = 1'b1;
    enable = 1'b1;
    keypad = '0;
    idle(3);
    clear = 1'b0;
    chk("rst_digit",   32'(digit),     0);
    chk("rst_valid",   32'(valid),     0);
    chk("rst_pressed", 32'(pressed),   0);
    chk("rst_multi",   32'(multi_err), 0);
    idle(5);

    // Clean press of 5.
    reset_log();
    keypad = 10'b0000100000; t_apply = cyc; idle(90);
    keypad = '0;             t_rel   = cyc; idle(20);
    n_str = strobe_q.size(); pad_log(1);
    chk("t1_strobes", n_str, 1);
    chk("t1_digit",   strobe_q[0], 5);
    chk("t1_latency", strobe_cyc[0] - t_apply, D + 1);
    chk("t1_release", fall_cyc - t_rel, D + 1);

    // Bounce on key 3, then stable.
    reset_log();
    for (int i = 0; i < 5; i++) begin
      keypad = (i % 2 == 1) ? 10'b0000001000 : 10'b0;
      idle(2);
    end
    keypad = 10'b0000001000; t_apply = cyc; idle(90);
    keypad = '0; idle(20);
    n_str = strobe_q.size(); pad_log(1);
    chk("t2_strobes", n_str, 1);
    chk("t2_digit",   strobe_q[0], 3);
    chk("t2_latency", strobe_cyc[0] - t_apply, D + 1);

    // Sequence 5, 0, 3.
    reset_log();
    for (int k = 0; k < 3; k++) begin
      keypad = 10'(1) << seq_keys[k]; idle(90);
      keypad = '0; idle(90);
    end
    n_str = strobe_q.size(); pad_log(3);
    chk("t3_strobes", n_str, 3);
    chk("t3_d0", strobe_q[0], 5);
    chk("t3_d1", strobe_q[1], 0);
    chk("t3_d2", strobe_q[2], 3);

    // Two keys together, then one, then release.
    reset_log();
    keypad = 10'b0000000110; idle(20);
    keypad = 10'b0000000010; idle(20);
    keypad = '0;             idle(20);
    chk("t4_strobes",  strobe_q.size(), 0);
    chk("t4_multi_hi", multi_hi, 20);
    chk("t4_pressed",  pressed_hi, 0);
    chk("t4_digit",    32'(digit), 3);

    // Press 7 with enable low, raise enable while held.
    reset_log();
    enable = 1'b0;
    keypad = 10'b0010000000; idle(30);
    enable = 1'b1;           idle(30);
    keypad = '0;             idle(20);
    chk("t5_strobes",    strobe_q.size(), 0);
    chk("t5_digit",      32'(digit), 7);
    chk("t5_pressed_hi", pressed_hi, 60);

    // Clear while holding 9; key still held re-debounces once.
    reset_log();
    keypad = 10'b1000000000; idle(20);
    n_str = strobe_q.size(); pad_log(1);
    chk("t6_pre_strobes", n_str, 1);
    chk("t6_pre_digit",   strobe_q[0], 9);
    chk("t6_pre_pressed", 32'(pressed), 1);
    clear = 1'b1; idle(1);
    clear = 1'b0; t_apply = cyc;
    chk("t6_clr_digit",   32'(digit),   0);
    chk("t6_clr_pressed", 32'(pressed), 0);
    chk("t6_clr_valid",   32'(valid),   0);
    reset_log();
    idle(30);
    n_str = strobe_q.size(); pad_log(1);
    chk("t6_strobes", n_str, 1);
    chk("t6_digit",   strobe_q[0], 9);
    chk("t6_latency", strobe_cyc[0] - t_apply, D + 1);
    keypad = '0; idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
